// File: rtl/mips_pkg.sv
// Shared MIPS instruction field layout and immediate-extension encodings
// used by the instruction field pipe and its splitter.
package mips_pkg;

  localparam int INSTR_W    = 32;

  localparam int OPCODE_LSB = 26;
  localparam int OPCODE_W   = 6;
  localparam int RS_LSB     = 21;
  localparam int RS_W       = 5;
  localparam int RT_LSB     = 16;
  localparam int RT_W       = 5;
  localparam int RD_LSB     = 11;
  localparam int RD_W       = 5;
  localparam int SHAMT_LSB  = 6;
  localparam int SHAMT_W    = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int FUNCT_W    = 6;
  localparam int IMM_LSB    = 0;
  localparam int IMM_W      = 16;
  localparam int JIDX_W     = 26;
  // Jump targets keep the PC+4 bits from this position upward.
  localparam int JREGION_LSB = 28;

  localparam logic EXT_ZERO = 1'b0;
  localparam logic EXT_SIGN = 1'b1;

endpackage

// File: rtl/instr_field_split.sv
// Purely combinational MIPS field splitter: decodes one captured instruction
// and derives the extended immediate, PC+4 and the J-type jump target.
module instr_field_split
  import mips_pkg::*;
#(
  parameter int IMM_EXT_W = 32,
  parameter int PC_W      = 32
) (
  input  logic [INSTR_W-1:0]   instr,
  input  logic [PC_W-1:0]      pc,
  input  logic                 ext_sel,
  output logic [OPCODE_W-1:0]  opcode,
  output logic [RS_W-1:0]      rs,
  output logic [RT_W-1:0]      rt,
  output logic [RD_W-1:0]      rd,
  output logic [SHAMT_W-1:0]   shamt,
  output logic [FUNCT_W-1:0]   funct,
  output logic [IMM_W-1:0]     immediate,
  output logic [IMM_EXT_W-1:0] imm_ext,
  output logic [PC_W-1:0]      jaddr,
  output logic [PC_W-1:0]      pc4
);

  assign opcode    = instr[OPCODE_LSB +: OPCODE_W];
  assign rs        = instr[RS_LSB +: RS_W];
  assign rt        = instr[RT_LSB +: RT_W];
  assign rd        = instr[RD_LSB +: RD_W];
  assign shamt     = instr[SHAMT_LSB +: SHAMT_W];
  assign funct     = instr[FUNCT_LSB +: FUNCT_W];
  assign immediate = instr[IMM_LSB +: IMM_W];

  // Address arithmetic wraps naturally at 2^PC_W.
  assign pc4 = pc + PC_W'(3'd4);

  if (IMM_EXT_W > IMM_W) begin : g_imm_ext
    logic fill_s;
    assign fill_s  = (ext_sel == EXT_SIGN) & immediate[IMM_W-1];
    assign imm_ext = {{(IMM_EXT_W-IMM_W){fill_s}}, immediate};
  end else begin : g_imm_same
    assign imm_ext = immediate;
  end

  if (PC_W > JREGION_LSB) begin : g_jaddr_region
    assign jaddr = {pc4[PC_W-1:JREGION_LSB], instr[JIDX_W-1:0], 2'b00};
  end else begin : g_jaddr_flat
    assign jaddr = {instr[JIDX_W-1:0], 2'b00};
  end

endmodule

// File: rtl/instr_field_pipe.sv
// Handshaked instruction field stage: a 1- or 2-entry FIFO between fetch and
// decode, with the head entry decoded by a combinational field splitter.
module instr_field_pipe
  import mips_pkg::*;
#(
  parameter int IMM_EXT_W = 32,
  parameter int PC_W      = 32,
  parameter bit SKID_EN   = 1'b1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INSTR_W-1:0]   iDataOut,
  input  logic [PC_W-1:0]      iPC,
  input  logic                 ExtSel,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OPCODE_W-1:0]  Opcode,
  output logic [RS_W-1:0]      rs,
  output logic [RT_W-1:0]      rt,
  output logic [RD_W-1:0]      rd,
  output logic [SHAMT_W-1:0]   shamt,
  output logic [FUNCT_W-1:0]   funct,
  output logic [IMM_W-1:0]     immediate,
  output logic [IMM_EXT_W-1:0] imm_ext,
  output logic [PC_W-1:0]      jaddr,
  output logic [PC_W-1:0]      oPC,
  output logic [PC_W-1:0]      oPC4
);

  logic               head_valid_r, skid_valid_r;
  logic [INSTR_W-1:0] head_instr_r, skid_instr_r;
  logic [PC_W-1:0]    head_pc_r, skid_pc_r;
  logic               head_ext_r, skid_ext_r;
  logic               accept_s, pop_s;

  logic [OPCODE_W-1:0]  opcode_s;
  logic [RS_W-1:0]      rs_s;
  logic [RT_W-1:0]      rt_s;
  logic [RD_W-1:0]      rd_s;
  logic [SHAMT_W-1:0]   shamt_s;
  logic [FUNCT_W-1:0]   funct_s;
  logic [IMM_W-1:0]     imm_s;
  logic [IMM_EXT_W-1:0] imm_ext_s;
  logic [PC_W-1:0]      jaddr_s, pc4_s;

  if (SKID_EN) begin : g_skid
    assign in_ready = !skid_valid_r;
  end else begin : g_single
    assign in_ready = !head_valid_r || out_ready;
  end

  assign accept_s  = in_valid && in_ready;
  assign pop_s     = head_valid_r && out_ready;
  assign out_valid = head_valid_r;

  // Head/skid FIFO update; with SKID_EN=0 the skid branch can never be taken.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      head_valid_r <= 1'b0;
      head_instr_r <= '0;
      head_pc_r    <= '0;
      head_ext_r   <= 1'b0;
      skid_valid_r <= 1'b0;
      skid_instr_r <= '0;
      skid_pc_r    <= '0;
      skid_ext_r   <= 1'b0;
    end else if (flush) begin
      head_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
    end else if (pop_s && skid_valid_r) begin
      head_instr_r <= skid_instr_r;
      head_pc_r    <= skid_pc_r;
      head_ext_r   <= skid_ext_r;
      skid_valid_r <= 1'b0;
    end else if (accept_s && (!head_valid_r || pop_s)) begin
      head_valid_r <= 1'b1;
      head_instr_r <= iDataOut;
      head_pc_r    <= iPC;
      head_ext_r   <= ExtSel;
    end else if (accept_s) begin
      skid_valid_r <= 1'b1;
      skid_instr_r <= iDataOut;
      skid_pc_r    <= iPC;
      skid_ext_r   <= ExtSel;
    end else if (pop_s) begin
      head_valid_r <= 1'b0;
    end
  end

  instr_field_split #(
    .IMM_EXT_W (IMM_EXT_W),
    .PC_W      (PC_W)
  ) u_split (
    .instr     (head_instr_r),
    .pc        (head_pc_r),
    .ext_sel   (head_ext_r),
    .opcode    (opcode_s),
    .rs        (rs_s),
    .rt        (rt_s),
    .rd        (rd_s),
    .shamt     (shamt_s),
    .funct     (funct_s),
    .immediate (imm_s),
    .imm_ext   (imm_ext_s),
    .jaddr     (jaddr_s),
    .pc4       (pc4_s)
  );

  // Fields read as zero whenever the head is empty (reset, flush, drained).
  always_comb begin
    if (head_valid_r) begin
      Opcode    = opcode_s;
      rs        = rs_s;
      rt        = rt_s;
      rd        = rd_s;
      shamt     = shamt_s;
      funct     = funct_s;
      immediate = imm_s;
      imm_ext   = imm_ext_s;
      jaddr     = jaddr_s;
      oPC       = head_pc_r;
      oPC4      = pc4_s;
    end else begin
      Opcode    = '0;
      rs        = '0;
      rt        = '0;
      rd        = '0;
      shamt     = '0;
      funct     = '0;
      immediate = '0;
      imm_ext   = '0;
      jaddr     = '0;
      oPC       = '0;
      oPC4      = '0;
    end
  end

endmodule
